fpu_ret_collect: RTL

Collects the 14-bit completion returns of the three low-half FP store/convert units (ports u1, u3, u5) into one ordered queue for retirement. It accumulates sticky FP exception flags and raises a trap strobe on enabled exceptions. The block sits directly downstream of the low-half FP unit group and upstream of the retire logic. The FP units cannot stall, so the block drives an early `stall` to the scheduler.

---
 rtl/fpu_ret_collect_pkg.sv | 30 +++
 rtl/fpu_ret_collect_slotsel.sv | 26 ++
 rtl/fpu_ret_collect.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpu_ret_collect_pkg.sv
// Shared definitions for the low-half FP return collector: flag bit positions,
// return field ranges, port identifiers and the queue entry layout.
package fpu_ret_collect_pkg;

  localparam int FLG_INV = 0;
  localparam int FLG_DZ  = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 3;
  localparam int FLG_INX = 4;
  localparam int FLG_DEN = 5;
  localparam int FLG_W   = 6;

  localparam int RET_W    = 14;
  localparam int STAT_LSB = 6;
  localparam int STAT_MSB = 13;

  localparam logic [1:0] PID_U1 = 2'd0;
  localparam logic [1:0] PID_U3 = 2'd1;
  localparam logic [1:0] PID_U5 = 2'd2;

  typedef struct packed {
    logic [1:0]       port_id;
    logic [RET_W-1:0] ret;
  } ret_entry_t;

  function automatic logic [FLG_W-1:0] ret_flags(input logic [RET_W-1:0] ret);
    return ret[FLG_DEN:FLG_INV];
  endfunction

endpackage

// File: rtl/fpu_ret_collect_slotsel.sv
// Packs this cycle's valid returns into consecutive slots in u1, u3, u5 order,
// accepting only as many as there are free entries.
module fpu_ret_slotsel #(
  parameter int FW = 4
) (
  input  logic [2:0]      en_i,
  input  logic [FW-1:0]   free_i,
  output logic [2:0]      we_o,
  output logic [2:0][1:0] off_o,
  output logic [1:0]      n_wr_o
);

  // Slot offset of each port is its rank among the valid returns.
  always_comb begin
    off_o    = '0;
    we_o     = 3'b000;
    off_o[0] = 2'd0;
    off_o[1] = {1'b0, en_i[0]};
    off_o[2] = {1'b0, en_i[0]} + {1'b0, en_i[1]};
    for (int i = 0; i < 3; i++) begin
      we_o[i] = en_i[i] && (FW'(off_o[i]) < free_i);
    end
    n_wr_o = {1'b0, we_o[0]} + {1'b0, we_o[1]} + {1'b0, we_o[2]};
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// Ordered retirement queue for the u1/u3/u5 FP returns, with sticky exception
// flags, trap strobe, early scheduler stall and sticky overflow indication.
module fpu_ret_collect
  import fpu_ret_collect_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       fpcsr,
  input  logic [RET_W-1:0]  u1_ret,
  input  logic [RET_W-1:0]  u3_ret,
  input  logic [RET_W-1:0]  u5_ret,
  input  logic              u1_ret_en,
  input  logic              u3_ret_en,
  input  logic              u5_ret_en,
  output logic [15:0]       out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              stall,
  output logic [FLG_W-1:0]  fpflags,
  input  logic              flags_clr,
  output logic              trap,
  output logic              ovf_err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  ret_entry_t             mem_q [DEPTH];
  logic [AW:0]            count_q, count_d;
  logic [AW-1:0]          rptr_q, wptr_q;
  logic [FLG_W-1:0]       fpflags_q, fpflags_d;
  logic                   trap_q, trap_d;
  logic                   ovf_q, ovf_d;
  logic                   stall_q, stall_d;

  ret_entry_t [2:0]       ent;
  logic [2:0]             en;
  logic [2:0]             we;
  logic [2:0][1:0]        off;
  logic [1:0]             n_wr;
  logic [AW:0]            free;
  logic [2:0][AW-1:0]     waddr;
  logic [FLG_W-1:0]       acc_flags;
  logic                   deq;

  assign ent[0] = '{port_id: PID_U1, ret: u1_ret};
  assign ent[1] = '{port_id: PID_U3, ret: u3_ret};
  assign ent[2] = '{port_id: PID_U5, ret: u5_ret};
  assign en     = {u5_ret_en, u3_ret_en, u1_ret_en};

  // A same-cycle dequeue does not free a slot for this cycle's writes.
  assign free = DEPTH_C - count_q;

  fpu_ret_slotsel #(.FW(AW+1)) u_slotsel (
    .en_i   (en),
    .free_i (free),
    .we_o   (we),
    .off_o  (off),
    .n_wr_o (n_wr)
  );

  assign out_vld  = (count_q != '0);
  assign out_data = mem_q[rptr_q];
  assign stall    = stall_q;
  assign fpflags  = fpflags_q;
  assign trap     = trap_q;
  assign ovf_err  = ovf_q;

  // Next-state for occupancy, flags, trap, overflow and stall.
  always_comb begin
    deq       = out_vld && out_rdy;
    acc_flags = '0;
    for (int p = 0; p < 3; p++) begin
      waddr[p] = wptr_q + AW'(off[p]);
      if (we[p]) begin
        acc_flags = acc_flags | ret_flags(ent[p].ret);
      end else begin
        acc_flags = acc_flags;
      end
    end
    count_d   = count_q + (AW+1)'(n_wr) - (AW+1)'(deq);
    fpflags_d = (flags_clr ? '0 : fpflags_q) | acc_flags;
    trap_d    = |(acc_flags & fpcsr[FLG_W-1:0]);
    ovf_d     = ovf_q | (en != we);
    stall_d   = (DEPTH_C - count_d) < (AW+1)'(3);
  end

  // Control registers and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      fpflags_q <= '0;
      trap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      rptr_q    <= rptr_q + AW'(deq);
      wptr_q    <= wptr_q + AW'(n_wr);
      fpflags_q <= fpflags_d;
      trap_q    <= trap_d;
      ovf_q     <= ovf_d;
      stall_q   <= stall_d;
    end
  end

  // Entry storage; accepted returns land in distinct slots, so no write conflicts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        for (int p = 0; p < 3; p++) begin
          if (we[p] && (waddr[p] == AW'(j))) begin
            mem_q[j] <= ent[p];
          end
        end
      end
    end
  end

endmodule
